hrm_mem_arbiter: RTL and testbench
==================================

Name: hrm_mem_arbiter

Overview:
Shares the single synchronous-read data RAM between the CPU datapath and the debug/loader port. The debug/loader port is a UART-side engine that dumps and preloads tiles.
- Sequences each access through a fixed four-state handshake.
- Breaks ties with round-robin.
- Offers the debug side an exclusive lock that freezes CPU memory traffic, so memory can be inspected or preloaded while a program runs.

Parameters:
ADDR_W, 8, address width of data RAM (matches AR register)
DATA_W, 8, data word width (matches R register)

Ports:
clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
c_req  in  1  CPU request; held with c_we/c_addr/c_wdata stable until c_ack
c_we  in  1  CPU write enable (1=write, 0=read)
c_addr  in  ADDR_W  CPU address
c_wdata  in  DATA_W  CPU write data
c_rdata  out  DATA_W  CPU read data, valid while c_ack=1, held after
c_ack  out  1  one-cycle completion pulse to CPU
d_req  in  1  debug request, same protocol as c_req
d_we  in  1  debug write enable
d_addr  in  ADDR_W  debug address
d_wdata  in  DATA_W  debug write data
d_rdata  out  DATA_W  debug read data, valid while d_ack=1, held after
d_ack  out  1  one-cycle completion pulse to debug
d_lock  in  1  level; request exclusive ownership of the memory
d_lock_ack  out  1  lock granted; CPU requests stall while high
m_addr  out  ADDR_W  RAM address
m_we  out  1  RAM write enable
m_wdata  out  DATA_W  RAM write data
m_rdata  in  DATA_W  RAM read data, valid one cycle after the address is sampled
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - Outputs: all outputs 0.
  - State and arbitration: state=IDLE, last_grant=DBG, so the CPU wins the first tie.
  - Internal registers: all zeroed.
- FSM states: IDLE, ACCESS, CAPTURE, DONE. All transitions are unconditional except those leaving IDLE.
- IDLE:
  - Eligible requesters: CPU eligible iff c_req && !d_lock_ack; debug eligible iff d_req.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant: register the winner's addr/we/wdata into the m_* output registers, update last_grant, go to ACCESS.
  - No eligible requester: stay in IDLE with m_we=0.
- ACCESS:
  - m_addr/m_wdata/m_we drive the RAM; the RAM samples them at the end of this cycle, so writes commit here.
  - m_we is high only in ACCESS.
  - Next state: CAPTURE.
- CAPTURE:
  - m_rdata is valid; on a read, load it into the granted port's rdata register. The other port's rdata is untouched.
  - Next state: DONE.
- DONE:
  - Granted port's ack=1 for exactly this cycle.
  - Next state: IDLE.
- Latency: req seen in IDLE cycle N -> ack in cycle N+3. Earliest next grant is N+4 (throughput of one access per 4 cycles).
- Write acks: write transactions also ack. rdata is unchanged on a write.
- Lock:
  - d_lock_ack rises at the end of an IDLE cycle where d_lock=1. An in-flight CPU transaction therefore finishes before the lock is granted.
  - d_lock_ack falls on the first clock edge where d_lock=0.
  - While locked, debug transactions proceed normally.
  - While locked, c_req is ignored (no ack); the CPU control unit waits in its memory state.
- Protocol violation: dropping req before ack does not abort the transaction. It completes and acks anyway.
- Back-to-back: keeping req high after ack starts a new transaction if that port wins arbitration in the following IDLE.
- Asynchronous reset mid-transaction:
  - Immediate return to IDLE; m_we drops at once; no ack is emitted.
  - A write already sampled by the RAM stays committed.
- Addresses: no wrap or range check; the full ADDR_W space is passed through.

Decomposition:
- Shared package hrm_pkg holds:
  - State encoding constants: IDLE=2'b00, ACCESS=2'b01, CAPTURE=2'b10, DONE=2'b11.
  - Requester IDs: CPU=1'b0, DBG=1'b1.
- Natural sub-module: hrm_rr_pick2, a combinational two-requester round-robin pick. Inputs: eligible vector and last_grant. Outputs: grant_valid and grant_id.
- The FSM, datapath registers and lock logic remain in hrm_mem_arbiter.

Test Plan:
- CPU read: RAM[0x05]=0x2A; c_req=1, c_we=0, c_addr=0x05 at cycle N -> m_addr=0x05 in N+1; c_ack=1 and c_rdata=0x2A in N+3 only; d_ack stays 0.
- Debug write then CPU read: d_we=1, d_addr=0x10, d_wdata=0x7F -> m_we=1 for exactly one cycle. Then CPU reads 0x10 -> c_rdata=0x7F.
- Tie round-robin: c_req and d_req held high together from reset -> grant order CPU, DBG, CPU, DBG; acks at cycles 3, 7, 11, 15.
- Lock during CPU access: c_req read in flight, d_lock raised in ACCESS -> c_ack still pulses; d_lock_ack rises afterwards. A held c_req gets no ack while locked. On d_lock=0 the CPU is granted in the next IDLE.
- Reset mid-write: i_rst asserted during ACCESS -> m_we, busy, c_ack and d_ack all 0 immediately; state IDLE; the next CPU request acks 3 cycles after it is seen.
- Early req drop: c_req deasserted in ACCESS -> c_ack still pulses in DONE; the FSM then idles with busy=0.

Source files
------------

// File: rtl/hrm_pkg.sv
// Shared types for the data-RAM arbiter.
// Holds FSM state encoding and requester IDs.
package hrm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;

endpackage

// File: rtl/hrm_rr_pick2.sv
// Two-requester round-robin pick (combinational).
// Ports: elig[0]=CPU, elig[1]=DBG, last_grant in; grant_valid, grant_id out.
module hrm_rr_pick2
  import hrm_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |elig;
    grant_id    = CPU;
    if (&elig)
      grant_id = ~last_grant;
    else if (elig[1])
      grant_id = DBG;
  end

endmodule

// File: rtl/hrm_mem_arbiter.sv
// Arbitrates the synchronous-read data RAM between CPU and debug port.
// Ports: clk/i_rst; c_* CPU side; d_* debug side + lock; m_* RAM side; busy.
module hrm_mem_arbiter
  import hrm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  input  logic              d_lock,
  output logic              d_lock_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  state_t state_q, state_d;
  logic   gnt_q;
  logic   last_q;
  logic   we_q;
  logic   gv;
  logic   gid;
  logic   take;

  hrm_rr_pick2 u_pick (
    .elig        ({d_req, c_req & ~d_lock_ack}),
    .last_grant  (last_q),
    .grant_valid (gv),
    .grant_id    (gid)
  );

  assign take = (state_q == IDLE) && gv;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gv) state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= CPU;
      last_q     <= DBG;
      we_q       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      d_lock_ack <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        gnt_q   <= gid;
        last_q  <= gid;
        we_q    <= (gid == DBG) ? d_we    : c_we;
        m_addr  <= (gid == DBG) ? d_addr  : c_addr;
        m_wdata <= (gid == DBG) ? d_wdata : c_wdata;
      end
      if (state_q == CAPTURE && !we_q) begin
        if (gnt_q == DBG) d_rdata <= m_rdata;
        else              c_rdata <= m_rdata;
      end
      // Lock is only taken between transactions, so any
      // CPU access already underway runs to completion.
      if (!d_lock)
        d_lock_ack <= 1'b0;
      else if (state_q == IDLE)
        d_lock_ack <= 1'b1;
    end
  end

  assign m_we  = we_q && (state_q == ACCESS);
  assign c_ack = (state_q == DONE) && (gnt_q == CPU);
  assign d_ack = (state_q == DONE) && (gnt_q == DBG);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_hrm_mem_arbiter.sv
// Scoreboard bench for hrm_mem_arbiter.
// Directed vectors; monitor pops expected rdata on each ack.
module tb_hrm_mem_arbiter;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       c_req, c_we;
  logic [7:0] c_addr, c_wdata, c_rdata;
  logic       c_ack;
  logic       d_req, d_we;
  logic [7:0] d_addr, d_wdata, d_rdata;
  logic       d_ack, d_lock, d_lock_ack;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic       m_we, busy;

  logic [7:0] ram [256];
  logic [7:0] cq [$];
  logic [7:0] dq [$];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  hrm_mem_arbiter dut (
    .clk(clk), .i_rst(i_rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .d_lock(d_lock), .d_lock_ack(d_lock_ack),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (m_we) ram[m_addr] <= m_wdata;
    m_rdata <= ram[m_addr];
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_we) we_cnt++;
    if (!i_rst && c_ack) begin
      if (cq.size() == 0) check("c_ack_unexpected", 1, 0);
      else check("c_rdata", c_rdata, cq.pop_front());
    end
    if (!i_rst && d_ack) begin
      if (dq.size() == 0) check("d_ack_unexpected", 1, 0);
      else check("d_rdata", d_rdata, dq.pop_front());
    end
  end

  task automatic wait_ack(input bit dbg, input string nm);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dbg ? d_ack : c_ack;
    end
    check(nm, seen, 1);
  endtask

  task automatic cpu(input logic we, input logic [7:0] a,
                     input logic [7:0] wd);
    c_req = 1; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic dbg(input logic we, input logic [7:0] a,
                     input logic [7:0] wd);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h05] = 8'h2A;
    i_rst = 1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", {c_ack, d_ack, d_lock_ack, m_we, busy}, 0);
    check("rst_data", {c_rdata, d_rdata, m_addr, m_wdata}, 0);
    i_rst = 0;
    @(negedge clk);

    // CPU read of 0x05
    cpu(0, 8'h05, 0); cq.push_back(8'h2A);
    @(negedge clk);
    check("t1_maddr", m_addr, 8'h05);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_noack_n2", c_ack, 0);
    @(negedge clk);
    check("t1_ack_n3", c_ack, 1);
    c_req = 0;
    @(negedge clk);
    check("t1_ack_1cyc", c_ack, 0);

    // debug write 0x10 <- 0x7F, then CPU reads it back
    we_cnt = 0;
    dbg(1, 8'h10, 8'h7F); dq.push_back(8'h00);
    wait_ack(1, "t2_dack");
    d_req = 0;
    check("t2_we_pulses", we_cnt, 1);
    @(negedge clk);
    cpu(0, 8'h10, 0); cq.push_back(8'h7F);
    wait_ack(0, "t2_cack");
    c_req = 0;
    @(negedge clk);

    // tie from reset: CPU, DBG, CPU, DBG
    i_rst = 1;
    @(negedge clk);
    cpu(0, 8'h05, 0); dbg(0, 8'h10, 0);
    cq.push_back(8'h2A); cq.push_back(8'h2A);
    dq.push_back(8'h7F); dq.push_back(8'h7F);
    i_rst = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("t3_cack_%0d", k), c_ack, (k == 3 || k == 11));
      check($sformatf("t3_dack_%0d", k), d_ack, (k == 7 || k == 15));
    end
    c_req = 0; d_req = 0;
    @(negedge clk);

    // lock raised while a CPU read is in flight
    cpu(0, 8'h05, 0); cq.push_back(8'h2A);
    @(negedge clk);
    d_lock = 1;
    wait_ack(0, "t4_cack_inflight");
    check("t4_lock_not_yet", d_lock_ack, 0);
    c_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("t4_lock_ack", d_lock_ack, 1);
    cpu(0, 8'h05, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t4_cpu_stalled", {c_ack, busy}, 0);
    end
    dbg(0, 8'h10, 0); dq.push_back(8'h7F);
    wait_ack(1, "t4_dbg_locked");
    d_req = 0;
    @(negedge clk);
    check("t4_idle_locked", busy, 0);
    cq.push_back(8'h2A);
    d_lock = 0;
    @(negedge clk);
    check("t4_lock_drop", d_lock_ack, 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_cack_%0d", k), c_ack, (k == 4));
    end
    c_req = 0;
    @(negedge clk);

    // async reset during a CPU write's ACCESS cycle
    cpu(1, 8'h20, 8'h55);
    @(negedge clk);
    check("t5_mwe", m_we, 1);
    #1 i_rst = 1;
    c_req = 0;
    #1;
    check("t5_rst_now", {m_we, busy, c_ack, d_ack}, 0);
    @(negedge clk);
    i_rst = 0;
    cpu(0, 8'h20, 0); cq.push_back(8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("t5_cack_%0d", k), c_ack, (k == 3));
    end
    c_req = 0;
    @(negedge clk);

    // req dropped during ACCESS still completes
    cpu(0, 8'h05, 0); cq.push_back(8'h2A);
    @(negedge clk);
    c_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("t6_ack", c_ack, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_idle", {busy, c_ack}, 0);
    end

    check("cq_empty", cq.size(), 0);
    check("dq_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
